// File: rtl/pipe_stall_ctrl_if.sv
// Stall/flush sequencing bus between the pipeline stages and pipe_stall_ctrl.
// The master drives the hazard requests; the slave (the controller) returns stall control.
interface pipe_stall_ctrl_if #(
    parameter int unsigned CNT_W  = 6,
    parameter int unsigned PERF_W = 32
);
    logic              stallreq_id;
    logic              ex_mc_start;
    logic [CNT_W-1:0]  ex_mc_len;
    logic              flush_req;
    logic [5:0]        stall;
    logic              flush;
    logic              mc_busy;
    logic              mc_last;
    logic              mc_err;
    logic [PERF_W-1:0] stall_cycles;

    modport master (
        output stallreq_id, ex_mc_start, ex_mc_len, flush_req,
        input  stall, flush, mc_busy, mc_last, mc_err, stall_cycles
    );

    modport slave (
        input  stallreq_id, ex_mc_start, ex_mc_len, flush_req,
        output stall, flush, mc_busy, mc_last, mc_err, stall_cycles
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush sequencer: merges ID load-use, EX multi-cycle and exception flush
// into the per-stage stall vector, and owns the EX multi-cycle countdown.
module pipe_stall_ctrl #(
    parameter int unsigned CNT_W  = 6,
    parameter int unsigned PERF_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    pipe_stall_ctrl_if.slave   bus
);

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_ID   = 6'b000111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mc_err_q, mc_err_d;
    logic [PERF_W-1:0] stall_cycles_q;
    logic              busy_c, last_c, start_ok_c;
    logic [5:0]        stall_c;

    // Next-state and combinational stall decode; flush overrides everything
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        busy_c     = 1'b0;
        last_c     = 1'b0;
        start_ok_c = bus.ex_mc_start && (bus.ex_mc_len != '0);
        mc_err_d   = mc_err_q || ((state_q == ST_BUSY) && bus.ex_mc_start);

        if (bus.flush_req) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_ok_c) begin
                        busy_c = 1'b1;
                        if (bus.ex_mc_len == CNT_W'(1)) begin
                            last_c = 1'b1;
                        end else begin
                            state_d = ST_BUSY;
                            cnt_d   = bus.ex_mc_len - CNT_W'(1);
                        end
                    end
                end
                ST_BUSY: begin
                    busy_c = 1'b1;
                    cnt_d  = cnt_q - CNT_W'(1);
                    // <= 1 guards against a corrupted zero count locking the pipe
                    if (cnt_q <= CNT_W'(1)) begin
                        last_c  = 1'b1;
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        if (bus.flush_req) begin
            stall_c = STALL_NONE;
        end else if (busy_c) begin
            stall_c = STALL_EX;
        end else if (bus.stallreq_id) begin
            stall_c = STALL_ID;
        end else begin
            stall_c = STALL_NONE;
        end
    end

    // State, countdown, sticky error and saturating stalled-cycle counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            mc_err_q       <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mc_err_q <= mc_err_d;
            if (stall_c[0] && (stall_cycles_q != '1)) begin
                stall_cycles_q <= stall_cycles_q + PERF_W'(1);
            end
        end
    end

    assign bus.stall        = stall_c;
    assign bus.flush        = bus.flush_req;
    assign bus.mc_busy      = busy_c;
    assign bus.mc_last      = last_c;
    assign bus.mc_err       = mc_err_q;
    assign bus.stall_cycles = stall_cycles_q;

endmodule
